// File: rtl/sfr_pkg.sv
// Shared types and constants for the SFR bus master.
package sfr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } sfr_state_e;

  // Wide enough for READ_LATENCY up to 15
  localparam int CNT_W = 4;

endpackage

// File: rtl/sfr_master.sv
// Single-outstanding command-to-SFR bus master with registered bus and response outputs.
// A write pulses we for one cycle; a read holds re for READ_LATENCY cycles, then responds.
module sfr_master
  import sfr_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  we,
  output logic                  re,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  sfr_state_e       state;
  sfr_state_e       state_n;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = req_write ? WRITE : READ;
      WRITE:   state_n = RESP;
      READ:    if (cnt == '0) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      we         <= 1'b0;
      re         <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      address    <= '0;
      write_data <= '0;
      cnt        <= '0;
    end else begin
      req_ready <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
      we        <= (state_n == WRITE);
      re        <= (state_n == READ);
      rsp_valid <= (state_n == RESP);

      if (state == IDLE && req_valid) begin
        address <= req_addr;
        if (req_write) begin
          write_data <= req_wdata;
        end else begin
          cnt <= CNT_LOAD;
        end
      end

      if (state == WRITE) begin
        rsp_write <= 1'b1;
        rsp_rdata <= '0;
      end

      // Capture happens on the edge that closes the last re cycle.
      if (state == READ) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rsp_write <= 1'b0;
          rsp_rdata <= read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_sfr_master.sv
// Bench for sfr_master: two instances (READ_LATENCY 1 and 3), each driving its own SFR target.
module tb_sfr_master;

  logic       clk;
  logic [1:0] reset;
  logic [1:0] req_valid, req_ready, req_write;
  logic [1:0][7:0] req_addr, req_wdata;
  logic [1:0] rsp_valid, rsp_ready, rsp_write;
  logic [1:0][7:0] rsp_rdata, address, write_data, read_data;
  logic [1:0] we, re, busy;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic       mem_clr;

  // Expected SFR contents, updated from issued writes only
  logic [7:0] refm [2][256];

  int total = 0;
  int passed = 0;

  sfr_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_write(rsp_write[0]),
    .rsp_rdata(rsp_rdata[0]), .address(address[0]), .write_data(write_data[0]),
    .we(we[0]), .re(re[0]), .read_data(read_data[0]), .busy(busy[0])
  );

  sfr_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_write(rsp_write[1]),
    .rsp_rdata(rsp_rdata[1]), .address(address[1]), .write_data(write_data[1]),
    .we(we[1]), .re(re[1]), .read_data(read_data[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int a = 0; a < 256; a++) begin
        mem0[a] <= 8'h00;
        mem1[a] <= 8'h00;
      end
    end else begin
      if (we[0]) mem0[address[0]] <= write_data[0];
      if (we[1]) mem1[address[1]] <= write_data[1];
    end
  end

  assign read_data[0] = mem0[address[0]];
  assign read_data[1] = mem1[address[1]];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk({tag, "_req_ready"}, req_ready[i], 1);
    chk({tag, "_rsp_valid"}, rsp_valid[i], 0);
    chk({tag, "_we"}, we[i], 0);
    chk({tag, "_re"}, re[i], 0);
    chk({tag, "_busy"}, busy[i], 0);
  endtask

  // One full transaction: issue, watch the bus, check the response, optionally backpressure.
  task automatic txn(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d,
                     input int hold, input bit offer2);
    int lat, n, wec, rec, both;
    logic [7:0] exp_rd;
    logic       s_wr;
    logic [7:0] s_rd;
    exp_rd = wr ? 8'h00 : refm[i][a];
    @(negedge clk);
    chk("accept_ready", req_ready[i], 1);
    req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = a; req_wdata[i] = d;
    rsp_ready[i] = 1'b0;
    @(negedge clk);
    req_valid[i] = 1'b0; req_wdata[i] = 8'($urandom); req_addr[i] = 8'($urandom);
    n = 1; lat = 0; wec = 0; rec = 0; both = 0;
    while (n <= 40 && lat == 0) begin
      if (we[i]) begin
        wec++;
        chk("we_address", address[i], a);
        chk("we_data", write_data[i], d);
      end
      if (re[i]) begin
        rec++;
        chk("re_address", address[i], a);
      end
      if (we[i] && re[i]) both++;
      if (rsp_valid[i]) lat = n;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("rsp_latency", lat, wr ? 2 : lat_of(i) + 1);
    chk("we_cycles", wec, wr ? 1 : 0);
    chk("re_cycles", rec, wr ? 0 : lat_of(i));
    chk("we_re_overlap", both, 0);
    chk("rsp_write", rsp_write[i], wr);
    chk("rsp_rdata", rsp_rdata[i], exp_rd);
    chk("busy_resp", busy[i], 1);
    if (wr) refm[i][a] = d;
    s_wr = rsp_write[i];
    s_rd = rsp_rdata[i];
    for (int k = 0; k < hold; k++) begin
      if (offer2) begin
        req_valid[i] = 1'b1; req_write[i] = k[0]; req_addr[i] = 8'h40; req_wdata[i] = 8'h5A;
      end
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid[i], 1);
      chk("bp_rsp_write", rsp_write[i], s_wr);
      chk("bp_rsp_rdata", rsp_rdata[i], s_rd);
      chk("bp_req_ready", req_ready[i], 0);
      chk("bp_bus_quiet", {we[i], re[i]}, 0);
    end
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready[i] = 1'b0;
    req_valid[i] = 1'b0;
    chk_idle(i, "post_rsp");
  endtask

  initial begin
    int seen;
    reset = 2'b11; mem_clr = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) refm[i][a] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 2'b00; mem_clr = 1'b0;

    for (int i = 0; i < 2; i++) begin
      chk_idle(i, "reset");
      chk("reset_rsp_write", rsp_write[i], 0);
      chk("reset_rsp_rdata", rsp_rdata[i], 0);
      chk("reset_address", address[i], 0);
      chk("reset_write_data", write_data[i], 0);
    end

    // Directed write then read-back at latency 1
    txn(0, 1'b1, 8'h12, 8'hA5, 0, 1'b0);
    txn(0, 1'b0, 8'h12, 8'h00, 0, 1'b0);
    chk("hold_address", address[0], 8'h12);
    chk("hold_write_data", write_data[0], 8'hA5);

    // Latency 3 read
    txn(1, 1'b1, 8'h12, 8'hA5, 0, 1'b0);
    txn(1, 1'b0, 8'h12, 8'h00, 0, 1'b0);

    // Backpressure with a second request offered
    txn(0, 1'b0, 8'h12, 8'h00, 5, 1'b1);
    txn(1, 1'b1, 8'h33, 8'h77, 5, 1'b1);

    // Reset during the second re cycle of a latency-3 read
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 8'h12;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("abort_re1", re[1], 1);
    @(negedge clk);
    chk("abort_re2", re[1], 1);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    chk_idle(1, "abort");
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1] || re[1]) seen++;
    end
    chk("abort_no_rsp", seen, 0);

    // Streamed writes then reads
    for (int k = 0; k < 4; k++) txn(0, 1'b1, 8'(k), 8'(8'h10 + k), 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      txn(0, 1'b0, 8'(k), 8'h00, 0, 1'b0);
      chk("stream_rdata", rsp_rdata[0], 8'(8'h10 + k));
    end

    // Randomized traffic on both instances
    for (int k = 0; k < 40; k++) begin
      txn(k % 2, 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom),
          int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sfr_master.md
SFR_MASTER -- requirements
Module: sfr_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning SFR bus address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning SFR bus data width in bits.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, legal range 1..15, meaning cycles re is held before read_data is sampled.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: command request valid.
REQ-007 The block SHALL have port req_ready, output, 1 bit: block can accept a command.
REQ-008 The block SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, ADDR_WIDTH bits: target address.
REQ-010 The block SHALL have port req_wdata, input, DATA_WIDTH bits: write data, ignored for reads.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: response valid.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: response consumer ready.
REQ-013 The block SHALL have port rsp_write, output, 1 bit: response belongs to a write.
REQ-014 The block SHALL have port rsp_rdata, output, DATA_WIDTH bits: read data, 0 for write responses.
REQ-015 The block SHALL have port address, output, ADDR_WIDTH bits: SFR bus address.
REQ-016 The block SHALL have port write_data, output, DATA_WIDTH bits: SFR bus write data.
REQ-017 The block SHALL have port we, output, 1 bit: SFR write enable; the target writes on a posedge where we=1.
REQ-018 The block SHALL have port re, output, 1 bit: SFR read enable.
REQ-019 The block SHALL have port read_data, input, DATA_WIDTH bits: SFR read data, combinational from address.
REQ-020 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, WRITE, READ, and RESP; all bus and response outputs SHALL be registered.
REQ-022 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted at a posedge where req_valid=1 and req_ready=1.
REQ-023 On acceptance, address SHALL load req_addr, and write_data SHALL load req_wdata for writes only.
REQ-024 Accepted write: the FSM SHALL go to WRITE with we=1 for exactly one cycle, then go to RESP with rsp_write=1 and rsp_rdata=0.
REQ-025 Accepted read: the FSM SHALL go to READ with re=1 for exactly READ_LATENCY cycles, counted by a 4-bit counter.
REQ-026 In READ, read_data SHALL be captured into rsp_rdata at the final re cycle's posedge; the FSM then goes to RESP with rsp_write=0.
REQ-027 In RESP, rsp_valid SHALL be 1, and rsp_write and rsp_rdata SHALL be stable until the posedge with rsp_ready=1; the FSM then goes to IDLE.
REQ-028 we and re SHALL never be 1 simultaneously, and both SHALL be 0 in IDLE and RESP.
REQ-029 address and write_data SHALL hold their last loaded values outside active bus cycles.
REQ-030 Minimum latency from acceptance to rsp_valid SHALL be 2 cycles for writes and READ_LATENCY+1 cycles for reads.
REQ-031 A request offered while req_ready=0 SHALL NOT be accepted; the requester holds it, and no request SHALL be accepted in the same cycle a response is consumed.
REQ-032 Back-to-back requests SHALL be serviced in order, one outstanding at a time.

Reset
REQ-033 reset=1 at a posedge SHALL force IDLE in any state, including mid-WRITE or mid-READ, with no response issued for the aborted transaction.
REQ-034 After reset: req_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0, address=0, write_data=0, we=0, re=0, busy=0, counter=0.

Structure
REQ-035 The state enum SHALL be defined in package sfr_pkg, together with the READ_LATENCY counter width constant.
REQ-036 sfr_master SHALL be a single module with no sub-modules.

Verification
REQ-037 Write: request write addr 0x12, data 0xA5 -> exactly one cycle with we=1, address=0x12, write_data=0xA5; rsp_valid 2 cycles later with rsp_write=1, rsp_rdata=0.
REQ-038 Read-back: after REQ-037, read 0x12 with READ_LATENCY=1 -> re high for 1 cycle; rsp_rdata=0xA5, rsp_write=0.
REQ-039 Latency: with READ_LATENCY=3, read 0x12 -> re high for exactly 3 cycles; rsp_valid on cycle 4 after acceptance.
REQ-040 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data held stable; req_ready=0 throughout, a second offered request is not accepted, and no we/re pulses occur.
REQ-041 Reset mid-read: assert reset during the 2nd re cycle with READ_LATENCY=3 -> next cycle re=0, rsp_valid=0, req_ready=1; no response ever appears.
REQ-042 Stream: 4 writes to 0x00..0x03 with data 0x10..0x13, then 4 reads of the same addresses -> responses arrive in order with rsp_rdata 0x10..0x13, and we/re are never both 1.
